// File: rtl/green_note_sprite_renderer.sv
// ---------------------------------------------------------------------------
// green_note_sprite_renderer
//
// Pixel-pipeline stage in front of the green note sprite frame RAM
// (4096 x 24, one-cycle registered read). For every scan position it decides
// whether the pixel lies on one of NOTES green note sprites in the green lane.
// It produces the sprite RAM read address, then colour-keys the returned RAM
// word into a registered sprite_on / sprite_rgb pair.
//
// Note positions are written into a shadow table at any time. They are copied
// into the active table only on frame_start, so a sprite never tears part way
// through a frame.
//
// Pipeline (inputs sampled at edge k):
//   edge k   : hit detection + address  -> read_address, hit_r1
//   edge k+1 : RAM registers ram_data;     hit_r1 -> hit_r2
//   edge k+2 : colour key               -> sprite_on, sprite_rgb
//
// Ports:
//   Clk          pixel clock
//   Reset_n      synchronous active-low reset
//   DrawX/DrawY  current scan column / row (10 bits each)
//   pix_valid    scan position is inside the visible area
//   frame_start  one-cycle pulse at vertical sync; commits shadow -> active
//   note_we      shadow table write strobe
//   note_idx     shadow entry to write
//   note_y       top row of the note sprite
//   note_vld     valid flag written together with note_y
//   read_address sprite RAM read address (row*64 + col, bit 12 always 0)
//   ram_data     sprite RAM read data
//   sprite_on    opaque green-note pixel (registered)
//   sprite_rgb   pixel colour, 0 when sprite_on is 0 (registered)
// ---------------------------------------------------------------------------
module green_note_sprite_renderer #(
    parameter int          NOTES      = 4,
    parameter int          LANE_X     = 160,
    parameter int          SPR_DIM    = 64,
    parameter logic [23:0] TRANSP_KEY = 24'hFF00FF,
    localparam int         IDX_W      = (NOTES > 1) ? $clog2(NOTES) : 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic             pix_valid,
    input  logic             frame_start,
    input  logic             note_we,
    input  logic [IDX_W-1:0] note_idx,
    input  logic [9:0]       note_y,
    input  logic             note_vld,
    output logic [12:0]      read_address,
    input  logic [23:0]      ram_data,
    output logic             sprite_on,
    output logic [23:0]      sprite_rgb
);

    // 11-bit bounds so that y + 63 near the bottom of the 10-bit range does
    // not wrap around and produce false hits / misses.
    localparam logic [10:0] LANE_LO  = 11'(LANE_X);
    localparam logic [10:0] LANE_HI  = 11'(LANE_X + SPR_DIM - 1);
    localparam logic [10:0] SPR_SPAN = 11'(SPR_DIM - 1);
    // Only the low six bits of the column offset reach the address, and those
    // depend only on the low six bits of the operands.
    localparam logic [5:0]  LANE_LO6 = 6'(LANE_X);

    logic [9:0]       shadow_y_r   [NOTES];
    logic [NOTES-1:0] shadow_vld_r;
    logic [9:0]       active_y_r   [NOTES];
    logic [NOTES-1:0] active_vld_r;

    logic             x_in_s;
    logic [NOTES-1:0] hit_s;
    logic             any_hit_s;
    logic [9:0]       y_win_s;
    logic [5:0]       row_s;
    logic [5:0]       col_s;
    logic [12:0]      addr_s;

    logic             hit_r1;
    logic             hit_r2;
    logic             opaque_s;

    // Shadow table: written by the note scheduler at any time.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NOTES; i++) begin
                shadow_y_r[i] <= 10'd0;
            end
            shadow_vld_r <= '0;
        end else if (note_we && (int'(note_idx) < NOTES)) begin
            shadow_y_r[note_idx]   <= note_y;
            shadow_vld_r[note_idx] <= note_vld;
        end
    end

    // Active table: takes the pre-edge shadow contents at frame start, so a
    // simultaneous note_we waits for the following frame.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NOTES; i++) begin
                active_y_r[i] <= 10'd0;
            end
            active_vld_r <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NOTES; i++) begin
                active_y_r[i] <= shadow_y_r[i];
            end
            active_vld_r <= shadow_vld_r;
        end
    end

    // Per-entry hit test against the active table.
    always_comb begin
        x_in_s = ({1'b0, DrawX} >= LANE_LO) && ({1'b0, DrawX} <= LANE_HI);
        hit_s  = '0;
        for (int i = 0; i < NOTES; i++) begin
            hit_s[i] = pix_valid && active_vld_r[i] && x_in_s
                       && ({1'b0, DrawY} >= {1'b0, active_y_r[i]})
                       && ({1'b0, DrawY} <= ({1'b0, active_y_r[i]} + SPR_SPAN));
        end
    end

    // Priority select: scanning downwards lets the lowest hitting index win.
    always_comb begin
        any_hit_s = 1'b0;
        y_win_s   = 10'd0;
        for (int i = NOTES - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                any_hit_s = 1'b1;
                y_win_s   = active_y_r[i];
            end else begin
                any_hit_s = any_hit_s;
                y_win_s   = y_win_s;
            end
        end
    end

    // Sprite-local address; forced to 0 on a miss.
    always_comb begin
        row_s = DrawY[5:0] - y_win_s[5:0];
        col_s = DrawX[5:0] - LANE_LO6;
        if (any_hit_s) begin
            addr_s = {1'b0, row_s, col_s};
        end else begin
            addr_s = 13'd0;
        end
    end

    // Colour key on the RAM word returned for the pixel two edges back.
    always_comb begin
        opaque_s = hit_r2 && (ram_data != TRANSP_KEY);
    end

    // Pipeline registers: address/hit, hit delay, keyed output.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            read_address <= 13'd0;
            hit_r1       <= 1'b0;
            hit_r2       <= 1'b0;
            sprite_on    <= 1'b0;
            sprite_rgb   <= 24'h000000;
        end else begin
            read_address <= addr_s;
            hit_r1       <= any_hit_s;
            hit_r2       <= hit_r1;
            sprite_on    <= opaque_s;
            sprite_rgb   <= opaque_s ? ram_data : 24'h000000;
        end
    end

endmodule

// File: tb/tb_green_note_sprite_renderer.sv
module tb_green_note_sprite_renderer;

    localparam int IDX_W = 2;

    logic             Clk;
    logic             Reset_n;
    logic [9:0]       DrawX;
    logic [9:0]       DrawY;
    logic             pix_valid;
    logic             frame_start;
    logic             note_we;
    logic [IDX_W-1:0] note_idx;
    logic [9:0]       note_y;
    logic             note_vld;
    logic [12:0]      read_address;
    logic [23:0]      ram_data;
    logic             sprite_on;
    logic [23:0]      sprite_rgb;

    int checks   = 0;
    int failures = 0;

    green_note_sprite_renderer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .pix_valid    (pix_valid),
        .frame_start  (frame_start),
        .note_we      (note_we),
        .note_idx     (note_idx),
        .note_y       (note_y),
        .note_vld     (note_vld),
        .read_address (read_address),
        .ram_data     (ram_data),
        .sprite_on    (sprite_on),
        .sprite_rgb   (sprite_rgb)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_note(input int idx, input logic vld, input int y);
        note_we  = 1'b1;
        note_idx = IDX_W'(idx);
        note_vld = vld;
        note_y   = 10'(y);
        tick();
        note_we  = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Hold one pixel for three edges: address after the first, output after the third.
    task automatic pix(input string tag, input int x, input int y, input logic [23:0] rd,
                       input logic [12:0] exp_addr, input logic exp_on, input logic [23:0] exp_rgb);
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        ram_data = rd;
        tick();
        chk({tag, "_addr"}, {19'd0, read_address}, {19'd0, exp_addr});
        tick();
        tick();
        chk({tag, "_on"}, {31'd0, sprite_on}, {31'd0, exp_on});
        chk({tag, "_rgb"}, {8'd0, sprite_rgb}, {8'd0, exp_rgb});
    endtask

    initial begin
        Reset_n     = 1'b0;
        DrawX       = 10'd0;
        DrawY       = 10'd0;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        note_we     = 1'b0;
        note_idx    = '0;
        note_y      = 10'd0;
        note_vld    = 1'b0;
        ram_data    = 24'h000000;

        tick();
        tick();
        chk("rst_addr", {19'd0, read_address}, 32'd0);
        chk("rst_on", {31'd0, sprite_on}, 32'd0);
        chk("rst_rgb", {8'd0, sprite_rgb}, 32'd0);

        Reset_n = 1'b1;
        wr_note(0, 1'b1, 100);
        commit();

        // First pixel with explicit latency checks.
        DrawX     = 10'd160;
        DrawY     = 10'd100;
        pix_valid = 1'b1;
        ram_data  = 24'h00C000;
        tick();
        chk("lat_addr_e1", {19'd0, read_address}, 32'd0);
        chk("lat_on_e1", {31'd0, sprite_on}, 32'd0);
        tick();
        chk("lat_on_e2", {31'd0, sprite_on}, 32'd0);
        tick();
        chk("lat_on_e3", {31'd0, sprite_on}, 32'd1);
        chk("lat_rgb_e3", {8'd0, sprite_rgb}, 32'h00C000);

        pix("corner", 223, 163, 24'h00C000, 13'd4095, 1'b1, 24'h00C000);

        // Miss right of lane: old hit still visible after edge 2, gone after edge 3.
        DrawX = 10'd224;
        tick();
        chk("xout_addr", {19'd0, read_address}, 32'd0);
        tick();
        chk("xout_on_e2", {31'd0, sprite_on}, 32'd1);
        tick();
        chk("xout_on_e3", {31'd0, sprite_on}, 32'd0);
        chk("xout_rgb_e3", {8'd0, sprite_rgb}, 32'd0);

        pix("mid", 200, 150, 24'h00A000, 13'd3240, 1'b1, 24'h00A000);
        pix("yout", 200, 164, 24'h00A000, 13'd0, 1'b0, 24'h000000);
        pix("mid2", 200, 150, 24'h00A000, 13'd3240, 1'b1, 24'h00A000);
        pix("xlow", 159, 150, 24'h00A000, 13'd0, 1'b0, 24'h000000);
        pix("yabove", 200, 99, 24'h00A000, 13'd0, 1'b0, 24'h000000);

        // Overlap: note 0 wins, then note 1 after invalidating note 0.
        wr_note(1, 1'b1, 130);
        commit();
        pix("prio0", 170, 140, 24'h00B000, 13'd2570, 1'b1, 24'h00B000);
        wr_note(0, 1'b0, 100);
        commit();
        pix("prio1", 170, 140, 24'h00B000, 13'd650, 1'b1, 24'h00B000);

        // Colour key.
        pix("key", 170, 140, 24'hFF00FF, 13'd650, 1'b0, 24'h000000);
        pix("nearkey", 170, 140, 24'hFF00FE, 13'd650, 1'b1, 24'hFF00FE);

        // pix_valid low masks a hit.
        pix_valid = 1'b0;
        pix("blank", 170, 140, 24'h00B000, 13'd0, 1'b0, 24'h000000);
        pix_valid = 1'b1;

        // Shadow write without commit has no effect.
        wr_note(2, 1'b1, 200);
        pix("nocommit", 161, 201, 24'h00D000, 13'd0, 1'b0, 24'h000000);

        // Commit with a simultaneous write: y=200 becomes active, y=300 waits.
        frame_start = 1'b1;
        note_we     = 1'b1;
        note_idx    = 2'd2;
        note_vld    = 1'b1;
        note_y      = 10'd300;
        tick();
        frame_start = 1'b0;
        note_we     = 1'b0;
        pix("sim_old", 161, 201, 24'h00D000, 13'd65, 1'b1, 24'h00D000);
        pix("sim_new_pend", 162, 301, 24'h00D000, 13'd0, 1'b0, 24'h000000);
        commit();
        pix("sim_new", 162, 301, 24'h00D000, 13'd66, 1'b1, 24'h00D000);

        // 11-bit compare: y=1000 covers rows 1000..1063, so row 1020 hits.
        wr_note(3, 1'b1, 1000);
        commit();
        pix("nowrap", 160, 1020, 24'h00E000, 13'd1280, 1'b1, 24'h00E000);
        pix("wrap_lo", 160, 20, 24'h00E000, 13'd0, 1'b0, 24'h000000);

        // Mid-stream reset flushes the pipeline and clears both tables.
        pix("pre_rst", 162, 301, 24'h00D000, 13'd66, 1'b1, 24'h00D000);
        Reset_n = 1'b0;
        tick();
        chk("rst_mid_addr", {19'd0, read_address}, 32'd0);
        chk("rst_mid_on", {31'd0, sprite_on}, 32'd0);
        chk("rst_mid_rgb", {8'd0, sprite_rgb}, 32'd0);
        Reset_n = 1'b1;
        pix("post_rst", 162, 301, 24'h00D000, 13'd0, 1'b0, 24'h000000);
        commit();
        pix("post_rst_commit_empty", 162, 301, 24'h00D000, 13'd0, 1'b0, 24'h000000);
        wr_note(0, 1'b1, 300);
        commit();
        pix("post_rst_new", 162, 301, 24'h00D000, 13'd66, 1'b1, 24'h00D000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/green_note_sprite_renderer.md
Name: green_note_sprite_renderer

Overview:
- Pixel-pipeline stage directly upstream of the green note sprite frame RAM, which is a 4096 x 24-bit RAM with 1-cycle registered read.
- Takes the VGA scan position and decides whether the pixel falls on one of up to NOTES green note sprites in the green lane.
- Generates the 13-bit sprite RAM read address.
- Consumes the 24-bit RAM output, applies colour-key transparency and presents a registered sprite_on/sprite_rgb pair to the colour mapper.
- Note positions are double-buffered and committed at frame start so sprites never tear mid-frame.

Parameters:
- NOTES, 4, number of simultaneously displayable green notes (1..8).
- LANE_X, 160, left screen column of the green lane; the sprite is 64 px wide.
- SPR_DIM, 64, sprite width/height in pixels; address = row*64 + col.
- TRANSP_KEY, 24'hFF00FF, RAM colour treated as transparent.

Ports:
- Clk  input  1  system clock (pixel clock domain)
- Reset_n  input  1  synchronous, active-low reset
- DrawX  input  10  current scan column
- DrawY  input  10  current scan row
- pix_valid  input  1  DrawX/DrawY are in the visible area this cycle
- frame_start  input  1  one-cycle pulse at vertical sync; commits shadow note registers
- note_we  input  1  write strobe for the shadow note table
- note_idx  input  $clog2(NOTES)  shadow entry to write
- note_y  input  10  top row of the note sprite
- note_vld  input  1  entry valid flag written with note_y
- read_address  output  13  to sprite RAM read_address
- ram_data  input  24  from sprite RAM data_Out
- sprite_on  output  1  registered: opaque green-note pixel at this position
- sprite_rgb  output  24  registered: pixel colour, 0 when sprite_on=0

Behaviour:
- Reset (Reset_n low at a rising edge): all shadow and active entries are invalid with y=0; read_address=0; all pipeline valid/hit flags are 0; sprite_on=0; sprite_rgb=0.
- Reset asserted mid-frame flushes the pipeline. Outputs are 0 from the first edge with Reset_n low.
- Shadow table: on note_we, shadow[note_idx] takes {note_vld, note_y} at the edge. No effect on the active table.
- Commit: on frame_start, active takes the shadow table as it stood before that edge.
  - A note_we in the same cycle updates shadow only and is committed at the next frame_start.
- Stage 0 (combinational, registered at edge k) computes per-entry hit[i]. hit[i] requires all of:
  - pix_valid = 1
  - active valid[i] = 1
  - LANE_X <= DrawX <= LANE_X+63
  - y[i] <= DrawY <= y[i]+63
  - The comparison uses 11-bit sums, so y near 1023 does not wrap.
- Priority: the lowest index with hit wins when sprites overlap.
- Address: read_address = {1'b0, (DrawY - y_win)[5:0], (DrawX - LANE_X)[5:0]}, registered at edge k. It is 0 when there is no hit. Bit 12 is always 0.
- Stage 1: hit flag delayed alongside the address. The RAM registers ram_data at edge k+1.
- Stage 2 (edge k+2):
  - sprite_on = hit_d2 && (ram_data != TRANSP_KEY)
  - sprite_rgb = sprite_on ? ram_data : 24'h0
- Latency: inputs sampled at edge k appear on sprite_on/sprite_rgb after edge k+2, i.e. 3 cycles. The throughput is one pixel per clock with no stalls. The upstream VGA stage compensates by delaying blanking/sync by 3 cycles.
- pix_valid low forces no hit and zero outputs 3 cycles later.
- DrawY < y[i]: no hit for that entry (no negative wrap).

Test Plan:
- Reset, then write shadow[0]={1,100}, pulse frame_start. Drive DrawX=160, DrawY=100, pix_valid=1 -> read_address=0 after edge 1. With ram_data=24'h00C000 -> sprite_on=1 and sprite_rgb=00C000 after edge 3.
- Same note, DrawX=223, DrawY=163 -> read_address=4095, sprite_on=1. Then DrawX=224 -> read_address=0 and sprite_on=0 3 cycles later. DrawY=164 -> sprite_on=0.
- Note0 y=100, note1 y=130, both valid. DrawX=170, DrawY=140 -> read_address=40*64+10=2570 (note0 wins). Invalidate note0 and commit -> read_address=10*64+10=650.
- ram_data=24'hFF00FF on a hit pixel -> sprite_on=0, sprite_rgb=0. ram_data=24'hFF00FE -> sprite_on=1, sprite_rgb=FF00FE.
- Write shadow[2]={1,200} mid-frame with no frame_start -> DrawX=160, DrawY=200 gives sprite_on=0. Pulse frame_start with note_we to shadow[2]={1,300} in the same cycle -> y=200 active and hits, y=300 not active until the next frame_start.
- Stream hit pixels, assert Reset_n=0 for one cycle -> sprite_on=0, sprite_rgb=0 and read_address=0 after that edge. The active table is invalid, so no hits after release until a commit.
